// File: rtl/fft_ram_scheduler_if.sv
// Bundle of the AXI-side, core-side and RAM-side request/response signals around the
// shared-sample-RAM scheduler. slave = scheduler, master = surrounding environment.
interface fft_ram_scheduler_if #(
   parameter int ADDR_W  = 12,
   parameter int WDATA_W = 16,
   parameter int RDATA_W = 32
);
   logic               axi_wr;
   logic               axi_rd;
   logic [ADDR_W-1:0]  axi_addr;
   logic [WDATA_W-1:0] axi_wdata;
   logic               data_loaded;
   logic [ADDR_W-1:0]  samples_number;
   logic [RDATA_W-1:0] axi_rdata;
   logic               axi_rvalid;
   logic               axi_busy;

   logic               core_start;
   logic               core_wr;
   logic               core_rd;
   logic [ADDR_W-1:0]  core_addr;
   logic [WDATA_W-1:0] core_wdata;
   logic               core_done;
   logic [RDATA_W-1:0] core_rdata;
   logic               core_rvalid;

   logic               ram_mode;
   logic               ram_wr;
   logic               ram_rd;
   logic [ADDR_W-1:0]  ram_addr;
   logic [WDATA_W-1:0] ram_wdata;
   logic [RDATA_W-1:0] ram_rdata;

   logic               calc_end;
   logic [1:0]         state;
   logic               timeout;

   modport slave (
      input  axi_wr, axi_rd, axi_addr, axi_wdata, data_loaded, samples_number,
      input  core_wr, core_rd, core_addr, core_wdata, core_done,
      input  ram_rdata,
      output axi_rdata, axi_rvalid, axi_busy, core_start, core_rdata, core_rvalid,
      output ram_mode, ram_wr, ram_rd, ram_addr, ram_wdata, calc_end, state, timeout
   );

   modport master (
      output axi_wr, axi_rd, axi_addr, axi_wdata, data_loaded, samples_number,
      output core_wr, core_rd, core_addr, core_wdata, core_done,
      output ram_rdata,
      input  axi_rdata, axi_rvalid, axi_busy, core_start, core_rdata, core_rvalid,
      input  ram_mode, ram_wr, ram_rd, ram_addr, ram_wdata, calc_end, state, timeout
   );
endinterface

// File: rtl/fft_ram_scheduler.sv
// Sequences one FFT frame over the shared sample RAM: AXI load -> core start -> compute ->
// AXI readout. Define FFT_RAM_SCHED_TIMEOUT_EN to enable the CALC watchdog (TIMEOUT_CYC).
module fft_ram_scheduler #(
   parameter int ADDR_W      = 12,
   parameter int WDATA_W     = 16,
   parameter int RDATA_W     = 32,
   parameter int TIMEOUT_CYC = 4096
) (
   input logic                i_clk,
   input logic                i_rst,
   fft_ram_scheduler_if.slave bus
);
   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_START   = 2'd1,
      ST_CALC    = 2'd2,
      ST_READOUT = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   state_t          state;
   logic [ADDR_W:0] rd_count;
   logic [ADDR_W:0] rd_target;
   logic            last_read;
   logic            axi_fwd_wr, axi_fwd_rd, core_fwd_wr, core_fwd_rd;
   logic            ram_mode_q, core_start_q, axi_busy_q, calc_end_q;
   logic            axi_rvalid_q, core_rvalid_q;

`ifdef FFT_RAM_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] calc_cnt;
   logic             calc_expired;
   logic             timeout_q;
   assign calc_expired = (calc_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign bus.timeout  = timeout_q;
`else
   assign bus.timeout  = 1'b0;
`endif

   // Only the phase owner's strobes reach the RAM; START forwards nothing so the mode
   // switch never coincides with a RAM access.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      axi_fwd_wr  = 1'b0;
      axi_fwd_rd  = 1'b0;
      core_fwd_wr = 1'b0;
      core_fwd_rd = 1'b0;
      unique case (state)
         ST_LOAD: begin
            axi_fwd_wr = bus.axi_wr;
            axi_fwd_rd = bus.axi_rd & ~bus.axi_wr;
         end
         ST_CALC: begin
            core_fwd_wr = bus.core_wr;
            core_fwd_rd = bus.core_rd;
         end
         ST_READOUT: axi_fwd_rd = bus.axi_rd;
         ST_START: ;
      endcase
   end

   assign rd_target = (bus.samples_number == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                 : {1'b0, bus.samples_number};
   assign last_read = ((rd_count + CNT_ONE) == rd_target);

   assign bus.ram_wr    = axi_fwd_wr | core_fwd_wr;
   assign bus.ram_rd    = axi_fwd_rd | core_fwd_rd;
   assign bus.ram_addr  = (state == ST_CALC)  ? bus.core_addr :
                          (state == ST_START) ? {ADDR_W{1'b0}} : bus.axi_addr;
   assign bus.ram_wdata = (state == ST_CALC)  ? bus.core_wdata :
                          (state == ST_START) ? {WDATA_W{1'b0}} : bus.axi_wdata;

   assign bus.ram_mode    = ram_mode_q;
   assign bus.core_start  = core_start_q;
   assign bus.axi_busy    = axi_busy_q;
   assign bus.calc_end    = calc_end_q;
   assign bus.state       = state;
   assign bus.axi_rvalid  = axi_rvalid_q;
   assign bus.core_rvalid = core_rvalid_q;
   assign bus.axi_rdata   = axi_rvalid_q  ? bus.ram_rdata : {RDATA_W{1'b0}};
   assign bus.core_rdata  = core_rvalid_q ? bus.ram_rdata : {RDATA_W{1'b0}};

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= ST_LOAD;
         ram_mode_q    <= 1'b1;
         core_start_q  <= 1'b0;
         axi_busy_q    <= 1'b0;
         calc_end_q    <= 1'b0;
         axi_rvalid_q  <= 1'b0;
         core_rvalid_q <= 1'b0;
         rd_count      <= '0;
`ifdef FFT_RAM_SCHED_TIMEOUT_EN
         calc_cnt      <= '0;
         timeout_q     <= 1'b0;
`endif
      end else begin
         // The rvalid flags double as the return-side tag of the issuing port.
         axi_rvalid_q  <= axi_fwd_rd;
         core_rvalid_q <= core_fwd_rd;
         core_start_q  <= 1'b0;
         unique case (state)
            ST_LOAD: begin
               if (bus.data_loaded) begin
                  state        <= ST_START;
                  ram_mode_q   <= 1'b0;
                  core_start_q <= 1'b1;
                  axi_busy_q   <= 1'b1;
               end
            end
            ST_START: begin
               state <= ST_CALC;
`ifdef FFT_RAM_SCHED_TIMEOUT_EN
               calc_cnt <= '0;
`endif
            end
            ST_CALC: begin
               if (bus.core_done) begin
                  state      <= ST_READOUT;
                  ram_mode_q <= 1'b1;
                  axi_busy_q <= 1'b0;
                  calc_end_q <= 1'b1;
               end
`ifdef FFT_RAM_SCHED_TIMEOUT_EN
               else if (calc_expired) begin
                  state      <= ST_LOAD;
                  ram_mode_q <= 1'b1;
                  axi_busy_q <= 1'b0;
                  timeout_q  <= 1'b1;
               end else begin
                  calc_cnt <= calc_cnt + CNT_W'(1);
               end
`endif
            end
            ST_READOUT: begin
               if (axi_fwd_rd) begin
                  if (last_read) begin
                     state      <= ST_LOAD;
                     rd_count   <= '0;
                     calc_end_q <= 1'b0;
                  end else begin
                     rd_count <= rd_count + CNT_ONE;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fft_ram_scheduler.sv
// Randomized frame-level bench for fft_ram_scheduler: behavioural RAM plus a phase-level
// reference model of ownership, forwarding, read returns and frame sequencing.
module tb_fft_ram_scheduler;
   localparam int ADDR_W      = 6;
   localparam int WDATA_W     = 16;
   localparam int RDATA_W     = 32;
   localparam int TIMEOUT_CYC = 16;
   localparam int DEPTH       = 1 << ADDR_W;
`ifdef FFT_RAM_SCHED_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fft_ram_scheduler_if #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W)) bus ();

   fft_ram_scheduler #(
      .ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   // Behavioural RAM: stores a 32-bit word derived from the 16-bit sample, 1-cycle read.
   logic [RDATA_W-1:0] ram_mem [DEPTH];
   always @(posedge clk) begin
      if (bus.ram_wr) ram_mem[bus.ram_addr] <= {~bus.ram_wdata, bus.ram_wdata};
      if (bus.ram_rd) bus.ram_rdata <= ram_mem[bus.ram_addr];
      else            bus.ram_rdata <= $urandom;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: phase 0..3 = LOAD, START, CALC, READOUT.
   int                 m_phase   = 0;
   int                 m_reads   = 0;
   int                 m_calc    = 0;
   bit                 m_timeout = 1'b0;
   bit                 p_axi_rv  = 1'b0;
   bit                 p_core_rv = 1'b0;
   logic [RDATA_W-1:0] p_data    = '0;
   logic [RDATA_W-1:0] exp_mem [DEPTH];

   task automatic idle_inputs();
      bus.axi_wr      = 1'b0;  bus.axi_rd     = 1'b0;
      bus.axi_addr    = '0;    bus.axi_wdata  = '0;
      bus.data_loaded = 1'b0;  bus.core_done  = 1'b0;
      bus.core_wr     = 1'b0;  bus.core_rd    = 1'b0;
      bus.core_addr   = '0;    bus.core_wdata = '0;
   endtask

   // One clock: check outputs at the falling edge, then advance the model at the rising edge.
   task automatic step();
      bit                 e_axi_wr, e_axi_rd, e_core_wr, e_core_rd, e_wr, e_rd;
      logic [ADDR_W-1:0]  e_addr;
      logic [WDATA_W-1:0] e_wdata;
      int                 n;
      @(negedge clk);
      e_axi_wr  = (m_phase == 0) && bus.axi_wr;
      e_axi_rd  = ((m_phase == 0) && bus.axi_rd && !bus.axi_wr) || ((m_phase == 3) && bus.axi_rd);
      e_core_wr = (m_phase == 2) && bus.core_wr;
      e_core_rd = (m_phase == 2) && bus.core_rd;
      e_wr      = e_axi_wr || e_core_wr;
      e_rd      = e_axi_rd || e_core_rd;
      e_addr    = (m_phase == 2) ? bus.core_addr  : bus.axi_addr;
      e_wdata   = (m_phase == 2) ? bus.core_wdata : bus.axi_wdata;

      check("state",     64'(bus.state),      64'(m_phase));
      check("ram_mode",  64'(bus.ram_mode),   64'(m_phase == 0 || m_phase == 3));
      check("core_start",64'(bus.core_start), 64'(m_phase == 1));
      check("axi_busy",  64'(bus.axi_busy),   64'(m_phase == 1 || m_phase == 2));
      check("calc_end",  64'(bus.calc_end),   64'(m_phase == 3));
      check("ram_wr",    64'(bus.ram_wr),     64'(e_wr));
      check("ram_rd",    64'(bus.ram_rd),     64'(e_rd));
      if (e_wr || e_rd) check("ram_addr",  64'(bus.ram_addr),  64'(e_addr));
      if (e_wr)         check("ram_wdata", 64'(bus.ram_wdata), 64'(e_wdata));
      check("axi_rvalid",  64'(bus.axi_rvalid),  64'(p_axi_rv));
      check("core_rvalid", 64'(bus.core_rvalid), 64'(p_core_rv));
      if (p_axi_rv)  check("axi_rdata",  64'(bus.axi_rdata),  64'(p_data));
      if (p_core_rv) check("core_rdata", 64'(bus.core_rdata), 64'(p_data));
      check("timeout", 64'(bus.timeout), 64'(m_timeout));

      @(posedge clk);
      if (rst) begin
         m_phase = 0; m_reads = 0; m_calc = 0; m_timeout = 1'b0;
         p_axi_rv = 1'b0; p_core_rv = 1'b0;
      end else begin
         p_axi_rv  = e_axi_rd;
         p_core_rv = e_core_rd;
         if (e_rd) p_data = exp_mem[e_addr];
         if (e_wr) exp_mem[e_addr] = {~e_wdata, e_wdata};
         n = (bus.samples_number == '0) ? DEPTH : int'(bus.samples_number);
         case (m_phase)
            0: if (bus.data_loaded) m_phase = 1;
            1: begin m_phase = 2; m_calc = 0; end
            2: begin
               m_calc++;
               if (bus.core_done) m_phase = 3;
               else if (TO_EN && m_calc >= TIMEOUT_CYC) begin m_phase = 0; m_timeout = 1'b1; end
            end
            default: if (e_axi_rd) begin
               m_reads++;
               if (m_reads == n) begin m_phase = 0; m_reads = 0; end
            end
         endcase
      end
      #1;
   endtask

   task automatic random_core_op(input int n);
      case ($urandom_range(0, 2))
         1: begin bus.core_wr = 1'b1; bus.core_addr = ADDR_W'($urandom_range(0, n-1)); bus.core_wdata = WDATA_W'($urandom); end
         2: begin bus.core_rd = 1'b1; bus.core_addr = ADDR_W'($urandom_range(0, n-1)); end
         default: ;
      endcase
   endtask

   task automatic run_frame(input int n_field, input int done_delay);
      int n;
      int reads;
      n = (n_field == 0) ? DEPTH : n_field;
      bus.samples_number = ADDR_W'(n_field);
      for (int a = 0; a < n; a++) begin
         if (a > 0 && $urandom_range(0, 3) == 0) begin
            idle_inputs();
            bus.axi_rd   = 1'b1;
            bus.axi_addr = ADDR_W'($urandom_range(0, a-1));
            bus.core_done = 1'($urandom);
            step();
         end
         idle_inputs();
         bus.axi_wr    = 1'b1;
         bus.axi_addr  = ADDR_W'(a);
         bus.axi_wdata = WDATA_W'($urandom);
         bus.axi_rd    = (a == 5) || ($urandom_range(0, 5) == 0);
         random_core_op(n);
         step();
      end
      idle_inputs();
      bus.data_loaded = 1'b1;
      step();
      for (int i = 0; i <= done_delay; i++) begin
         idle_inputs();
         bus.axi_wr      = 1'($urandom);
         bus.axi_rd      = 1'($urandom);
         bus.axi_addr    = ADDR_W'($urandom_range(0, n-1));
         bus.axi_wdata   = WDATA_W'($urandom);
         bus.data_loaded = ($urandom_range(0, 7) == 0);
         bus.core_done   = (i == done_delay);
         random_core_op(n);
         step();
      end
      reads = 0;
      while (reads < n) begin
         idle_inputs();
         bus.axi_wr    = 1'($urandom);
         bus.axi_wdata = WDATA_W'($urandom);
         bus.axi_addr  = ADDR_W'($urandom_range(0, n-1));
         if ($urandom_range(0, 3) != 0) begin
            bus.axi_rd   = 1'b1;
            bus.axi_addr = ADDR_W'(reads);
            reads++;
         end else begin
            bus.core_done = 1'($urandom);
            random_core_op(n);
         end
         step();
      end
      idle_inputs();
      repeat (2) step();
   endtask

   task automatic reset_in_calc();
      bus.samples_number = ADDR_W'(4);
      for (int a = 0; a < 4; a++) begin
         idle_inputs();
         bus.axi_wr = 1'b1; bus.axi_addr = ADDR_W'(a); bus.axi_wdata = WDATA_W'($urandom);
         step();
      end
      idle_inputs(); bus.data_loaded = 1'b1; step();
      idle_inputs(); step();
      step();
      idle_inputs(); bus.core_rd = 1'b1; bus.core_addr = ADDR_W'(1); rst = 1'b1; step();
      idle_inputs(); rst = 1'b0; repeat (3) step();
   endtask

   initial begin
      idle_inputs();
      bus.samples_number = '0;
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      repeat (3) step();
      run_frame(0, 20);
      run_frame(8, 20);
      for (int f = 0; f < 6; f++) run_frame($urandom_range(1, 20), $urandom_range(2, 12));
      reset_in_calc();
      run_frame(4, 30);
      run_frame(6, 10);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
